// File: rtl/fifo_wr_arbiter.sv
// fifo_wr_arbiter: shares one 8-bit synchronous FIFO write port between N requesters.
// Round-robin selection with burst lock. Each grant holds the port until the burst ends,
// which happens at req_last, after MAX_BURST beats, or when the owner drops req.
// An internal credit counter (occ) tracks the beats the arbiter has sent to the FIFO.
// The arbiter never offers a beat while occ == DEPTH.
//
// Ports:
//   clk, rst_n     clock, asynchronous active-low reset
//   req[N]         per-requester data valid
//   req_data[N*8]  requester i data on bits [8i+7:8i]
//   req_last[N]    final beat of requester i's burst
//   gnt[N]         one-hot accept strobe, combinational, beat taken this cycle
//   owner          index of current burst owner
//   busy           high while in BURST
//   fifo_we        registered write strobe to FIFO
//   fifo_din       registered write data to FIFO (held when fifo_we is low)
//   fifo_pop       FIFO read accepted this cycle
//   occ            credit-counter occupancy
//
// Optional feature, enabled by defining FIFO_ARB_STATS_EN:
//   grant_cnt[N*16]  saturating accepted-beat counter per requester
//   stall_cnt[16]    saturating count of BURST cycles stalled on a full FIFO
module fifo_wr_arbiter #(
    parameter int unsigned N         = 4,
    parameter int unsigned DEPTH     = 16,
    parameter int unsigned MAX_BURST = 4
) (
    input  logic                         clk,
    input  logic                         rst_n,
    input  logic [N-1:0]                 req,
    input  logic [N*8-1:0]               req_data,
    input  logic [N-1:0]                 req_last,
    output logic [N-1:0]                 gnt,
    output logic [$clog2(N)-1:0]         owner,
    output logic                         busy,
    output logic                         fifo_we,
    output logic [7:0]                   fifo_din,
    input  logic                         fifo_pop,
    output logic [$clog2(DEPTH+1)-1:0]   occ
`ifdef FIFO_ARB_STATS_EN
    ,
    output logic [N*16-1:0]              grant_cnt,
    output logic [15:0]                  stall_cnt
`endif
);

    localparam int unsigned OW   = $clog2(N);
    localparam int unsigned OCCW = $clog2(DEPTH + 1);
    localparam int unsigned BW   = $clog2(MAX_BURST + 1);

    localparam logic StIdle  = 1'b0;
    localparam logic StBurst = 1'b1;

    logic            state_q, state_d;
    logic [OW-1:0]   owner_q, owner_d;
    logic [OW-1:0]   rr_ptr_q, rr_ptr_d;
    logic [BW-1:0]   beat_cnt_q, beat_cnt_d;
    logic [OCCW-1:0] occ_q, occ_d;
    logic            fifo_we_q;
    logic [7:0]      fifo_din_q, fifo_din_d;

    logic            accept;
    logic            stall;
    logic            pick_valid;
    logic [OW-1:0]   pick_idx;
    logic [7:0]      owner_data;

    assign owner_data = req_data[owner_q*8 +: 8];

    // Accept uses the registered occ, so a pop at full frees credit only next cycle.
    assign accept = (state_q == StBurst) && req[owner_q] && (occ_q < OCCW'(DEPTH));
    assign stall  = (state_q == StBurst) && req[owner_q] && (occ_q == OCCW'(DEPTH));

    always_comb begin
        gnt = '0;
        if (accept) begin
            gnt[owner_q] = 1'b1;
        end
    end

    // Round-robin search starting just after the last owner.
    always_comb begin
        int idx;
        pick_valid = 1'b0;
        pick_idx   = '0;
        idx        = 0;
        for (int i = 1; i <= int'(N); i++) begin
            idx = (int'(rr_ptr_q) + i) % int'(N);
            if (!pick_valid && req[idx]) begin
                pick_valid = 1'b1;
                pick_idx   = OW'(idx);
            end
        end
    end

    always_comb begin
        state_d    = state_q;
        owner_d    = owner_q;
        rr_ptr_d   = rr_ptr_q;
        beat_cnt_d = beat_cnt_q;
        unique case (state_q)
            StIdle: begin
                if (pick_valid) begin
                    owner_d    = pick_idx;
                    beat_cnt_d = '0;
                    state_d    = StBurst;
                end
            end
            StBurst: begin
                if (accept) begin
                    beat_cnt_d = beat_cnt_q + 1'b1;
                end
                if (!req[owner_q] ||
                    (accept && (req_last[owner_q] || beat_cnt_q == BW'(MAX_BURST - 1)))) begin
                    state_d  = StIdle;
                    rr_ptr_d = owner_q;
                end
            end
            default: state_d = StIdle;
        endcase
    end

    always_comb begin
        occ_d = occ_q;
        if (accept && !fifo_pop) begin
            occ_d = occ_q + 1'b1;
        end else if (!accept && fifo_pop && occ_q != '0) begin
            occ_d = occ_q - 1'b1;
        end
    end

    assign fifo_din_d = accept ? owner_data : fifo_din_q;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q    <= StIdle;
            owner_q    <= '0;
            rr_ptr_q   <= OW'(N - 1);
            beat_cnt_q <= '0;
            occ_q      <= '0;
            fifo_we_q  <= 1'b0;
            fifo_din_q <= 8'h00;
        end else begin
            state_q    <= state_d;
            owner_q    <= owner_d;
            rr_ptr_q   <= rr_ptr_d;
            beat_cnt_q <= beat_cnt_d;
            occ_q      <= occ_d;
            fifo_we_q  <= accept;
            fifo_din_q <= fifo_din_d;
        end
    end

    assign owner    = owner_q;
    assign busy     = (state_q == StBurst);
    assign fifo_we  = fifo_we_q;
    assign fifo_din = fifo_din_q;
    assign occ      = occ_q;

`ifdef FIFO_ARB_STATS_EN
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            grant_cnt <= '0;
            stall_cnt <= '0;
        end else begin
            for (int i = 0; i < int'(N); i++) begin
                if (gnt[i] && grant_cnt[i*16 +: 16] != 16'hFFFF) begin
                    grant_cnt[i*16 +: 16] <= grant_cnt[i*16 +: 16] + 16'd1;
                end
            end
            if (stall && stall_cnt != 16'hFFFF) begin
                stall_cnt <= stall_cnt + 16'd1;
            end
        end
    end
`endif

endmodule

// File: tb/tb_fifo_wr_arbiter.sv
module tb_fifo_wr_arbiter;

    localparam int N     = 4;
    localparam int DEPTH = 16;

    logic          clk = 1'b0;
    logic          rst_n;
    logic [N-1:0]  req;
    logic [N*8-1:0] req_data;
    logic [N-1:0]  req_last;
    logic [N-1:0]  gnt;
    logic [1:0]    owner;
    logic          busy;
    logic          fifo_we;
    logic [7:0]    fifo_din;
    logic          fifo_pop;
    logic [4:0]    occ;
`ifdef FIFO_ARB_STATS_EN
    logic [N*16-1:0] grant_cnt;
    logic [15:0]     stall_cnt;
`endif

    int n_chk = 0;
    int n_bad = 0;

    fifo_wr_arbiter #(.N(4), .DEPTH(16), .MAX_BURST(4)) dut (
        .clk      (clk),
        .rst_n    (rst_n),
        .req      (req),
        .req_data (req_data),
        .req_last (req_last),
        .gnt      (gnt),
        .owner    (owner),
        .busy     (busy),
        .fifo_we  (fifo_we),
        .fifo_din (fifo_din),
        .fifo_pop (fifo_pop),
        .occ      (occ)
`ifdef FIFO_ARB_STATS_EN
        ,
        .grant_cnt (grant_cnt),
        .stall_cnt (stall_cnt)
`endif
    );

    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_chk++;
        if (got !== exp) begin
            n_bad++;
            $display("FAIL %s: got %0h want %0h", tag, got, exp);
        end
    endtask

    // Advance to just after the next rising edge; inputs are changed and outputs
    // sampled away from the edge.
    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic do_reset();
        rst_n    = 1'b0;
        req      = '0;
        req_last = '0;
        fifo_pop = 1'b0;
        repeat (2) @(posedge clk);
        #1;
        rst_n = 1'b1;
    endtask

    initial begin
        rst_n    = 1'b0;
        req      = '0;
        req_data = '0;
        req_last = '0;
        fifo_pop = 1'b0;
        #2;
        check("rst_gnt", 32'(gnt), 0);
        check("rst_owner", 32'(owner), 0);
        check("rst_busy", 32'(busy), 0);
        check("rst_we", 32'(fifo_we), 0);
        check("rst_din", 32'(fifo_din), 0);
        check("rst_occ", 32'(occ), 0);
        do_reset();

        // Single requester, three-beat burst
        req = 4'b0010;
        req_data[15:8] = 8'hA0;
        #1 check("s1_idle_gnt", 32'(gnt), 0);
        tick();
        check("s1_busy", 32'(busy), 1);
        check("s1_owner", 32'(owner), 1);
        check("s1_gnt0", 32'(gnt), 4'b0010);
        tick();
        check("s1_we0", 32'(fifo_we), 1);
        check("s1_din0", 32'(fifo_din), 8'hA0);
        check("s1_occ1", 32'(occ), 1);
        req_data[15:8] = 8'hA1;
        #1 check("s1_gnt1", 32'(gnt), 4'b0010);
        tick();
        check("s1_din1", 32'(fifo_din), 8'hA1);
        req_data[15:8] = 8'hA2;
        req_last = 4'b0010;
        #1 check("s1_gnt2", 32'(gnt), 4'b0010);
        tick();
        check("s1_we2", 32'(fifo_we), 1);
        check("s1_din2", 32'(fifo_din), 8'hA2);
        check("s1_occ3", 32'(occ), 3);
        check("s1_busy_end", 32'(busy), 0);
        req = '0;
        req_last = '0;
        tick();
        check("s1_we_low", 32'(fifo_we), 0);
        check("s1_din_hold", 32'(fifo_din), 8'hA2);

        // Drain, then pop at empty is ignored
        fifo_pop = 1'b1;
        repeat (3) tick();
        check("drain_occ", 32'(occ), 0);
        tick();
        check("pop_at_zero", 32'(occ), 0);
        fifo_pop = 1'b0;

        // Round-robin: 5 bursts of 4 beats, one IDLE cycle before each
        do_reset();
        req = 4'b1111;
        fifo_pop = 1'b1;
        for (int k = 0; k < 25; k++) begin
            logic [3:0] exp_g;
            exp_g = (k % 5 == 0) ? 4'b0000 : 4'(1 << ((k / 5) % 4));
            #1 check($sformatf("rr_gnt%0d", k), 32'(gnt), 32'(exp_g));
            tick();
        end
        req = '0;
        fifo_pop = 1'b0;

        // Full stall with requester 2
        do_reset();
        req = 4'b0100;
        begin
            int budget;
            budget = 0;
            while (!(busy && occ == 5'd16) && budget < 60) begin
                tick();
                budget++;
            end
            check("fill_timeout", 32'(budget < 60), 1);
        end
        #1 check("full_gnt", 32'(gnt), 0);
        check("full_busy", 32'(busy), 1);
        tick();
        check("full_gnt2", 32'(gnt), 0);
        check("full_occ", 32'(occ), 16);
        fifo_pop = 1'b1;
        #1 check("full_pop_gnt", 32'(gnt), 0);
        tick();
        fifo_pop = 1'b0;
        check("after_pop_occ", 32'(occ), 15);
        #1 check("after_pop_gnt", 32'(gnt), 4'b0100);
        tick();
        check("refill_occ", 32'(occ), 16);
        check("refill_gnt", 32'(gnt), 0);

        // Drop req and pop down to 7, then pop and accept together
        req = '0;
        fifo_pop = 1'b1;
        repeat (9) tick();
        check("occ7", 32'(occ), 7);
        check("occ7_idle", 32'(busy), 0);
        fifo_pop = 1'b0;
        req = 4'b0100;
        tick();
        fifo_pop = 1'b1;
        #1 check("both_gnt", 32'(gnt), 4'b0100);
        tick();
        check("both_occ", 32'(occ), 7);
        req = '0;
        fifo_pop = 1'b0;

        // Owner 0 drops after 2 beats, requester 3 pending
        do_reset();
        req = 4'b1001;
        tick();
        check("drop_owner0", 32'(owner), 0);
        #1 check("drop_gnt_a", 32'(gnt), 4'b0001);
        tick();
        #1 check("drop_gnt_b", 32'(gnt), 4'b0001);
        tick();
        req = 4'b1000;
        #1 check("drop_gnt_none", 32'(gnt), 0);
        tick();
        check("drop_idle", 32'(busy), 0);
        tick();
        check("drop_owner3", 32'(owner), 3);
        #1 check("drop_gnt3", 32'(gnt), 4'b1000);

        // Reset in a cycle with gnt[0] high
        req = '0;
        do_reset();
        req = 4'b0001;
        tick();
        #1 check("rst_mid_gnt", 32'(gnt), 4'b0001);
        rst_n = 1'b0;
        #1;
        check("rst_mid_busy", 32'(busy), 0);
        check("rst_mid_owner", 32'(owner), 0);
        tick();
        check("rst_mid_we", 32'(fifo_we), 0);
        check("rst_mid_occ", 32'(occ), 0);
        rst_n = 1'b1;
        #1 check("rst_rel_idle_gnt", 32'(gnt), 0);
        tick();
        #1 check("rst_rel_gnt", 32'(gnt), 4'b0001);
        tick();
        check("rst_rel_we", 32'(fifo_we), 1);

        $display("test done: total=%0d bad=%0d", n_chk, n_bad);
        $finish;
    end

endmodule

// File: doc/fifo_wr_arbiter.md
Name: fifo_wr_arbiter

Overview:
- Shares one 8-bit synchronous FIFO write port between N requesters.
- Round-robin arbitration with burst lock: a winner keeps the port until its last beat, the burst limit, or its request drops.
- Tracks FIFO occupancy with an internal credit counter, so no beat is ever offered to a full FIFO. This does not depend on the FIFO's registered full flag.
- Sits between producer blocks and the FIFO we/din/re pins.

Parameters:
- N, 4, number of requesters (2..8).
- DEPTH, 16, FIFO entries; credit counter ceiling.
- MAX_BURST, 4, maximum beats per grant (1..DEPTH).

Ports:
- clk  input  1  clock.
- rst_n  input  1  reset (see Behaviour: Reset).
- req  input  N  per-requester data valid.
- req_data  input  N*8  requester i data on bits [8i+7:8i].
- req_last  input  N  final beat of requester i's burst.
- gnt  output  N  one-hot accept strobe; beat taken this cycle.
- owner  output  $clog2(N)  index of current burst owner.
- busy  output  1  high while in BURST.
- fifo_we  output  1  registered write strobe to FIFO.
- fifo_din  output  8  registered write data to FIFO.
- fifo_pop  input  1  FIFO read accepted this cycle (re && not empty).
- occ  output  $clog2(DEPTH+1)  current credit-counter occupancy.

Behaviour:
- Reset: rst_n is asynchronous, active-low; clock is clk. While rst_n is low: state=IDLE, gnt=0, owner=0, busy=0, fifo_we=0, fifo_din=8'h00, occ=0, rr_ptr=N-1, beat_cnt=0.
- FSM states: IDLE, BURST.
- IDLE:
  - If any req bit is high, pick the first set bit searching rr_ptr+1, rr_ptr+2, ... modulo N.
  - Load owner, clear beat_cnt, go to BURST next cycle.
  - No gnt is issued in IDLE, so first accept latency is 1 cycle after req is seen.
- BURST, accept condition: accept = req[owner] && (occ < DEPTH).
- BURST, on accept:
  - gnt[owner]=1 (combinational, same cycle).
  - Next edge: fifo_we=1, fifo_din=req_data[owner], beat_cnt++.
- BURST exit to IDLE, taken on the next edge. Exit happens on any of:
  - accept && req_last[owner];
  - accept && beat_cnt==MAX_BURST-1;
  - req[owner]==0.
  - On every exit, rr_ptr=owner.
- BURST with req[owner]=1 and occ==DEPTH: stall in BURST with gnt=0. A stall does not count toward MAX_BURST.
- fifo_we/fifo_din:
  - fifo_we is a 1-cycle pulse per accepted beat.
  - fifo_din holds its last value when fifo_we=0.
- Credit counter occ: updated every edge.
  - +1 on accept without fifo_pop.
  - -1 on fifo_pop without accept.
  - Unchanged on both or neither.
  - fifo_pop with occ==0 is ignored; occ never underflows.
  - occ counts beats accepted, including the one still registered in fifo_we.
- Same-cycle pop at full: accept uses the registered occ. A pop when occ==DEPTH frees credit for the next cycle, not the current one.
- gnt is always one-hot or zero. Only the owner's req_data/req_last are sampled; other requesters' inputs are ignored during BURST.
- Reset mid-burst: immediate return to reset values. A beat whose gnt was issued in the cycle reset asserts is dropped (fifo_we forced 0).

Optional Feature:
- Macro: FIFO_ARB_STATS_EN.
- Defined:
  - Adds output grant_cnt (N*16 bits), one saturating 16-bit counter per requester, incremented on each accepted beat and cleared by reset.
  - Adds output stall_cnt (16 bits, saturating), counting BURST cycles with req[owner]=1 and occ==DEPTH.
- Undefined: neither port nor any counter logic exists; all other behaviour is identical.

Test Plan:
- Single requester: req=4'b0010, data 8'hA0..A2, last on third beat, no pops -> gnt[1] on 3 consecutive cycles starting 1 cycle after req; fifo_we pulses carry A0,A1,A2; occ=3; owner=1; back to IDLE.
- Round-robin: req=4'b1111 held, never last, MAX_BURST=4, fifo_pop every cycle -> owners granted in order 0,1,2,3,0; exactly 4 beats each; 1 IDLE cycle between bursts.
- Full stall: fill occ to 16 with no pops while requester 2 holds req -> gnt=0 and busy=1 while occ=16. Single fifo_pop -> occ=15 next cycle, one gnt[2] the cycle after, occ back to 16.
- Simultaneous pop and accept at occ=7 -> occ stays 7. fifo_pop at occ=0 -> occ stays 0.
- Owner drops req mid-burst after 2 beats, with req[3] pending -> IDLE next cycle; rr_ptr=owner; requester 3 wins next.
- Reset asserted in a cycle with gnt[0]=1 -> fifo_we stays 0, occ=0, owner=0, busy=0. After release with req=4'b0001 -> normal grant resumes 1 cycle later.
